// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit with architectural HI/LO registers.
// MULT/DIV results land in HI/LO only when the busy window expires.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cancel,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        rd_hi,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mdu_out
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       hi_q, hi_d, lo_q, lo_d;
  logic [31:0]       sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic              sh_wr_q, sh_wr_d;

  logic              accept;
  logic [63:0]       prod_s, prod_u;
  logic              sign_a, sign_b, div_zero;
  logic [31:0]       abs_a, abs_b, divisor_s, divisor_u;
  logic [31:0]       uq_s, ur_s, quot_s, rem_s, quot_u, rem_u;

  // Signed division via magnitudes so 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s    = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u    = {32'd0, rs_data} * {32'd0, rt_data};
    sign_a    = rs_data[31];
    sign_b    = rt_data[31];
    div_zero  = (rt_data == 32'd0);
    abs_a     = sign_a ? (32'd0 - rs_data) : rs_data;
    abs_b     = sign_b ? (32'd0 - rt_data) : rt_data;
    divisor_s = div_zero ? 32'd1 : abs_b;
    divisor_u = div_zero ? 32'd1 : rt_data;
    uq_s      = abs_a / divisor_s;
    ur_s      = abs_a % divisor_s;
    quot_s    = (sign_a ^ sign_b) ? (32'd0 - uq_s) : uq_s;
    rem_s     = sign_a ? (32'd0 - ur_s) : ur_s;
    quot_u    = rs_data / divisor_u;
    rem_u     = rs_data % divisor_u;
  end

  assign accept = start && !cancel && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_wr_d = sh_wr_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (op)
            OpMult, OpMultu: begin
              {sh_hi_d, sh_lo_d} = (op == OpMult) ? prod_s : prod_u;
              sh_wr_d = 1'b1;
              cnt_d   = CntW'(MULT_CYCLES);
              state_d = StRun;
            end
            OpDiv, OpDivu: begin
              sh_hi_d = (op == OpDiv) ? rem_s : rem_u;
              sh_lo_d = (op == OpDiv) ? quot_s : quot_u;
              sh_wr_d = !div_zero;
              cnt_d   = CntW'(DIV_CYCLES);
              state_d = StRun;
            end
            OpMthi:  hi_d = rs_data;
            OpMtlo:  lo_d = rs_data;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (sh_wr_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_wr_q <= sh_wr_d;
    end
  end

  assign busy    = (state_q == StRun);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign mdu_out = rd_hi ? hi_q : lo_q;

endmodule
